booth_pp_streamer: RTL and testbench

// - Producer side of the partial-product path: radix-4 Booth encoder that turns operand pair (a,b) into

---
 rtl/booth_pp_streamer.sv | 147 ++++++++++++++
 tb/tb_booth_pp_streamer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_pp_streamer.sv
// booth_pp_streamer: radix-4 Booth partial-product generator that streams one
// shifted, sign-extended row per cycle over a valid/ready interface.
// Optional feature macro: PP_SUM_CHECK_EN adds out_sum, the running sum of the
// rows of one operation (valid on the last row).
`ifndef BITWIDTH
`define BITWIDTH 8
`endif

module booth_pp_streamer #(
    parameter int unsigned BITWIDTH       = `BITWIDTH,
    parameter int unsigned LEASTSIGNIFCOL = 0
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [BITWIDTH-1:0]                         in_a,
    input  logic [BITWIDTH-1:0]                         in_b,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [2*BITWIDTH-1:0]                       out_row,
    output logic [((BITWIDTH/2 > 1) ? $clog2(BITWIDTH/2) : 1)-1:0] out_idx,
    output logic                                        out_first,
    output logic                                        out_last
`ifdef PP_SUM_CHECK_EN
    ,
    output logic [2*BITWIDTH-1:0]                       out_sum
`endif
);

    localparam int unsigned          NROWS     = BITWIDTH / 2;
    localparam int unsigned          IW        = (NROWS > 1) ? $clog2(NROWS) : 1;
    localparam logic [IW-1:0]        LAST_IDX  = IW'(NROWS - 1);
    localparam logic [2*BITWIDTH-1:0] KEEP_MASK = {(2*BITWIDTH){1'b1}} << LEASTSIGNIFCOL;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t                state, state_n;
    logic [BITWIDTH-1:0]   a_q, a_n;
    logic [BITWIDTH-1:0]   b_q, b_n;
    logic [IW-1:0]         idx_n;
    logic                  valid_n;
    logic [2*BITWIDTH-1:0] row_n;
    logic                  accept;
    logic                  fire;

    // One Booth row: digit from {b[2i+1], b[2i], b[2i-1]} times a, built in
    // BITWIDTH+2 bits so that -2*(-2^(W-1)) still fits, then sign-extended,
    // shifted into place and truncated below LEASTSIGNIFCOL.
    function automatic logic [2*BITWIDTH-1:0] booth_row(
        input logic [BITWIDTH-1:0] a,
        input logic [BITWIDTH-1:0] b,
        input logic [IW-1:0]       i
    );
        logic [BITWIDTH:0]     b_ext;
        logic [2:0]            trip;
        logic [BITWIDTH+1:0]   a_ext;
        logic [BITWIDTH+1:0]   a_neg;
        logic [BITWIDTH+1:0]   pp;
        logic [2*BITWIDTH-1:0] wide;
        b_ext = {b, 1'b0};
        trip  = b_ext[{i, 1'b0} +: 3];
        a_ext = {{2{a[BITWIDTH-1]}}, a};
        a_neg = ~a_ext + (BITWIDTH+2)'(1);
        case (trip)
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = {a_ext[BITWIDTH:0], 1'b0};
            3'b100:         pp = {a_neg[BITWIDTH:0], 1'b0};
            3'b101, 3'b110: pp = a_neg;
            default:        pp = '0;
        endcase
        wide = {{(BITWIDTH-2){pp[BITWIDTH+1]}}, pp};
        return (wide << {i, 1'b0}) & KEEP_MASK;
    endfunction

    // Handshakes, next state and the next registered row (computed from the
    // operands and index that will be current after this edge).
    always_comb begin
        state_n  = state;
        a_n      = a_q;
        b_n      = b_q;
        idx_n    = out_idx;
        in_ready = (state == IDLE) || (out_valid && out_last && out_ready);
        accept   = in_valid && in_ready;
        fire     = out_valid && out_ready;
        if (accept) begin
            a_n     = in_a;
            b_n     = in_b;
            idx_n   = '0;
            state_n = EMIT;
        end else if (fire) begin
            if (out_idx == LAST_IDX) begin
                idx_n   = '0;
                state_n = IDLE;
            end else begin
                idx_n = out_idx + IW'(1);
            end
        end
        valid_n = (state_n == EMIT);
        row_n   = booth_row(a_n, b_n, idx_n);
    end

    // State, latched operands and registered output row/flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_idx   <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_n;
            a_q       <= a_n;
            b_q       <= b_n;
            out_valid <= valid_n;
            out_row   <= valid_n ? row_n : '0;
            out_idx   <= idx_n;
            out_first <= valid_n && (idx_n == '0);
            out_last  <= valid_n && (idx_n == LAST_IDX);
        end
    end

`ifdef PP_SUM_CHECK_EN
    logic [2*BITWIDTH-1:0] acc;

    // Running sum of accepted rows; the first row restarts the sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (out_valid && out_ready) begin
            acc <= out_first ? out_row : acc + out_row;
        end
    end

    // Total of the operation, presented alongside the last row.
    always_comb begin
        out_sum = (out_valid && out_last) ? acc + out_row : '0;
    end
`endif

endmodule

// File: tb/tb_booth_pp_streamer.sv
// Bench for booth_pp_streamer (BITWIDTH=8): exact instance and an instance
// truncating columns below 4. Honours PP_SUM_CHECK_EN when defined.
module tb_booth_pp_streamer;

    typedef struct packed {
        logic [0:0]        sel;
        logic [7:0]        a;
        logic [7:0]        b;
        logic [3:0][15:0]  rows;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        out_ready = 1'b1;
    int unsigned cur = 0;

    logic        in_valid0, in_valid1;
    logic        rdy0, ov0, first0, last0;
    logic        rdy1, ov1, first1, last1;
    logic [15:0] row0, row1;
    logic [1:0]  idx0, idx1;
`ifdef PP_SUM_CHECK_EN
    logic [15:0] sum0, sum1;
`endif

    logic        m_rdy, m_ov, m_first, m_last;
    logic [15:0] m_row;
    logic [1:0]  m_idx;
    logic [15:0] m_sum;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl [8];

    assign in_valid0 = in_valid && (cur == 0);
    assign in_valid1 = in_valid && (cur == 1);

    always #5 clk = ~clk;

    booth_pp_streamer #(.BITWIDTH(8), .LEASTSIGNIFCOL(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(rdy0),
        .in_a(in_a), .in_b(in_b), .out_valid(ov0), .out_ready(out_ready),
        .out_row(row0), .out_idx(idx0), .out_first(first0), .out_last(last0)
`ifdef PP_SUM_CHECK_EN
        , .out_sum(sum0)
`endif
    );

    booth_pp_streamer #(.BITWIDTH(8), .LEASTSIGNIFCOL(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(rdy1),
        .in_a(in_a), .in_b(in_b), .out_valid(ov1), .out_ready(out_ready),
        .out_row(row1), .out_idx(idx1), .out_first(first1), .out_last(last1)
`ifdef PP_SUM_CHECK_EN
        , .out_sum(sum1)
`endif
    );

    always_comb begin
        m_rdy   = (cur == 0) ? rdy0   : rdy1;
        m_ov    = (cur == 0) ? ov0    : ov1;
        m_row   = (cur == 0) ? row0   : row1;
        m_idx   = (cur == 0) ? idx0   : idx1;
        m_first = (cur == 0) ? first0 : first1;
        m_last  = (cur == 0) ? last0  : last1;
`ifdef PP_SUM_CHECK_EN
        m_sum   = (cur == 0) ? sum0   : sum1;
`else
        m_sum   = '0;
`endif
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [0:0] sel, input logic [7:0] a, input logic [7:0] b,
                                input logic [15:0] r0, input logic [15:0] r1,
                                input logic [15:0] r2, input logic [15:0] r3);
        vec_t v;
        v.sel = sel; v.a = a; v.b = b;
        v.rows[0] = r0; v.rows[1] = r1; v.rows[2] = r2; v.rows[3] = r3;
        return v;
    endfunction

    // Present one pair with out_ready=1 and check all four rows.
    task automatic run_op(input vec_t v, input string tag);
        logic [15:0] acc;
        logic [15:0] exp_sum;
        logic [15:0] prod;
        cur = int'(v.sel);
        @(negedge clk);
        chk($sformatf("%s in_ready_idle", tag), 32'(m_rdy), 32'd1);
        in_a = v.a; in_b = v.b; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        acc = '0;
        exp_sum = v.rows[0] + v.rows[1] + v.rows[2] + v.rows[3];
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("%s valid[%0d]", tag, k), 32'(m_ov), 32'd1);
            chk($sformatf("%s idx[%0d]", tag, k), 32'(m_idx), 32'(k));
            chk($sformatf("%s row[%0d]", tag, k), 32'(m_row), 32'(v.rows[k]));
            chk($sformatf("%s first[%0d]", tag, k), 32'(m_first), 32'(k == 0));
            chk($sformatf("%s last[%0d]", tag, k), 32'(m_last), 32'(k == 3));
            acc = acc + m_row;
`ifdef PP_SUM_CHECK_EN
            if (k == 3) chk($sformatf("%s out_sum", tag), 32'(m_sum), 32'(exp_sum));
`endif
        end
        if (v.sel == 1'b0) begin
            prod = 16'($signed({{8{v.a[7]}}, v.a}) * $signed({{8{v.b[7]}}, v.b}));
            chk($sformatf("%s rowsum==a*b", tag), 32'(acc), 32'(prod));
        end
        @(negedge clk);
        chk($sformatf("%s valid_after", tag), 32'(m_ov), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = mk(1'b0, 8'h03, 8'h05, 16'h0003, 16'h000C, 16'h0000, 16'h0000);
        tbl[1] = mk(1'b0, 8'hF9, 8'h80, 16'h0000, 16'h0000, 16'h0000, 16'h0380);
        tbl[2] = mk(1'b0, 8'h80, 8'h80, 16'h0000, 16'h0000, 16'h0000, 16'h4000);
        tbl[3] = mk(1'b0, 8'h7F, 8'hFF, 16'hFF81, 16'h0000, 16'h0000, 16'h0000);
        tbl[4] = mk(1'b0, 8'h80, 8'h7F, 16'h0080, 16'h0000, 16'h0000, 16'hC000);
        tbl[5] = mk(1'b0, 8'hFF, 8'h33, 16'h0001, 16'hFFFC, 16'h0010, 16'hFFC0);
        tbl[6] = mk(1'b1, 8'h07, 8'h05, 16'h0000, 16'h0010, 16'h0000, 16'h0000);
        tbl[7] = mk(1'b1, 8'hFF, 8'h33, 16'h0000, 16'hFFF0, 16'h0010, 16'hFFC0);

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst out_valid0", 32'(ov0), 32'd0);
        chk("rst out_row0", 32'(row0), 32'd0);
        chk("rst out_idx0", 32'(idx0), 32'd0);
        chk("rst out_first0", 32'(first0), 32'd0);
        chk("rst out_last0", 32'(last0), 32'd0);
        chk("rst out_valid1", 32'(ov1), 32'd0);
`ifdef PP_SUM_CHECK_EN
        chk("rst out_sum0", 32'(sum0), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst in_ready0", 32'(rdy0), 32'd1);
        chk("post-rst in_ready1", 32'(rdy1), 32'd1);

        // Table-driven operations
        for (int i = 0; i < 8; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        // Stall: hold row 1 for three cycles with a competing input pending
        cur = 0;
        @(negedge clk);
        in_a = 8'h03; in_b = 8'h05; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall row0", 32'(row0), 32'h0003);
        @(negedge clk);
        chk("stall row1 presented", 32'(row0), 32'h000C);
        out_ready = 1'b0; in_a = 8'h01; in_b = 8'h01; in_valid = 1'b1;
        chk("stall in_ready", 32'(rdy0), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("stall hold row c%0d", c), 32'(row0), 32'h000C);
            chk($sformatf("stall hold idx c%0d", c), 32'(idx0), 32'd1);
            chk($sformatf("stall hold valid c%0d", c), 32'(ov0), 32'd1);
            chk($sformatf("stall in_ready c%0d", c), 32'(rdy0), 32'd0);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("stall resume idx", 32'(idx0), 32'd2);
        chk("stall resume row", 32'(row0), 32'h0000);
        @(negedge clk);
        chk("stall last idx", 32'(idx0), 32'd3);
        chk("stall last flag", 32'(last0), 32'd1);
        @(negedge clk);
        chk("stall done valid", 32'(ov0), 32'd0);

        // Back-to-back pair on last-row handshake, then reset during row 2
        in_a = 8'h03; in_b = 8'h05; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b last row", 32'(last0), 32'd1);
        chk("b2b in_ready on last", 32'(rdy0), 32'd1);
        in_a = 8'hF9; in_b = 8'h80; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b next valid", 32'(ov0), 32'd1);
        chk("b2b next idx", 32'(idx0), 32'd0);
        chk("b2b next first", 32'(first0), 32'd1);
        chk("b2b next row", 32'(row0), 32'h0000);
        @(negedge clk);
        chk("b2b row1 idx", 32'(idx0), 32'd1);
        @(negedge clk);
        chk("b2b row2 idx", 32'(idx0), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst out_valid", 32'(ov0), 32'd0);
        chk("midrst out_idx", 32'(idx0), 32'd0);
        chk("midrst out_row", 32'(row0), 32'd0);
        chk("midrst out_last", 32'(last0), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst in_ready after", 32'(rdy0), 32'd1);
        chk("midrst valid after", 32'(ov0), 32'd0);

        // Recovery after mid-operation reset
        run_op(tbl[1], "recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
